dec_to_hex_serial: RTL and testbench
====================================

# dec_to_hex_serial

Serial decimal-to-hexadecimal converter. It accepts a decimal number one BCD digit per handshake, most significant digit first, and accumulates it into a binary (hex) value. It then presents the result on an output valid/ready handshake. It is the inverse of the team's hex-to-decimal conversion path and sits between a digit source (keypad or UART parser) and any consumer of a binary value.

## Interface
- `N_DIGITS`, default 5: maximum decimal digits per number.
- `WIDTH`, default 16: result width in bits.
- `clk` in 1: clock; all logic on the rising edge.
- `rst_n` in 1: synchronous reset, active-low.
- `digit_valid` in 1: `digit` is offered this cycle.
- `digit` in 4: BCD digit, MSD first.
- `digit_last` in 1: qualifies `digit` as the final digit of the number.
- `digit_ready` out 1: block can accept a digit.
- `hex_out` out WIDTH: converted value.
- `hex_valid` out 1: `hex_out`, `overflow` and `err_digit` are valid.
- `hex_ready` in 1: consumer accepts the result.
- `overflow` out 1: the value exceeded 2^WIDTH−1, or more than N_DIGITS digits were received.
- `err_digit` out 1: at least one digit was greater than 9.
- `digit_count` out clog2(N_DIGITS+1): number of digits accepted for the current number, saturating at N_DIGITS.

## Operation
- There are three states: IDLE, ACCUM and HOLD.
- Reset values: state IDLE, internal accumulator 0, `hex_out` 0, `hex_valid` 0, `digit_ready` 0 during reset, `overflow` 0, `err_digit` 0, `digit_count` 0.
- `digit_ready` is 1 in IDLE and ACCUM and 0 in HOLD.
- A digit is accepted when `digit_valid` and `digit_ready` are both 1.
- Accumulation rule: acc ← acc×10 + d, where d is `digit`, or 0 if `digit` > 9.
  - The product is computed at WIDTH+4 bits.
  - If any bit above WIDTH−1 is set, `overflow` is set (sticky for this number).
- If `digit` > 9, `err_digit` is set (sticky for this number).
- Transitions:
  - IDLE → ACCUM on an accepted digit without `digit_last`. The accumulator and flags are loaded fresh from that digit; the previous number's flags are cleared.
  - IDLE → HOLD on an accepted digit with `digit_last`, for a single-digit number.
  - ACCUM → ACCUM on an accepted non-last digit.
  - ACCUM → HOLD on an accepted digit with `digit_last`.
  - HOLD → IDLE on `hex_valid` and `hex_ready`.
- Excess digits: if a digit is accepted while `digit_count` == N_DIGITS, `overflow` is set. The digit is consumed but not accumulated, and `digit_last` on it is still honoured.
- `hex_valid` is 1 exactly in HOLD. `hex_out` and the flags are stable for the whole of HOLD.
- `digit_count` holds its value through HOLD and clears on the next accepted first digit.

## Timing
- Each accepted digit updates the accumulator on the same edge.
- `hex_valid` rises on the cycle after the last digit is accepted.
- Minimum number period: k digit cycles + 1 HOLD cycle. With `hex_ready` tied high, the next first digit is accepted on the cycle after the result is taken.
- There is no combinational path from `hex_ready` to `digit_ready`. IDLE is entered registered.
- Backpressure: `hex_valid` stays high and `hex_out` holds until `hex_ready` is sampled high. Any number of stall cycles is allowed.
- `digit_valid` while `digit_ready` = 0 is ignored; no digit is lost from the block's side. The source must hold the digit.
- `rst_n` low in any state, including mid-number or in HOLD, returns all state to the reset values on that edge. The partial number is discarded and no result is emitted.

## Configuration
- `DEC_TO_HEX_SAT_EN` defined: when `overflow` is set, `hex_out` presents all ones (2^WIDTH−1) in HOLD.
- `DEC_TO_HEX_SAT_EN` not defined: `hex_out` presents the accumulator modulo 2^WIDTH. `overflow` is still flagged identically in both builds.

## Test plan
- Conversion: digits 1,2,3,4 (last on 4), `hex_ready`=1 → `hex_out`=16'h04D2 one cycle after the 4 is accepted, `overflow`=0, `err_digit`=0, `digit_count`=4.
- Boundary value: digits 6,5,5,3,5 → 16'hFFFF, `overflow`=0. Then 6,5,5,3,6 → `overflow`=1 and `hex_out`=16'h0000; with `DEC_TO_HEX_SAT_EN`, `hex_out`=16'hFFFF.
- Excess digits and bad digit:
  - Digits 1,0,0,0,0,7 with last on 7 → `overflow`=1, `hex_out`=16'h2710, `digit_count`=5.
  - Digits 4'hA,3 → `err_digit`=1, `hex_out`=16'h0003.
- Backpressure: result 16'h0009 held with `hex_ready`=0 for 5 cycles → `hex_valid` stays 1, `digit_ready`=0, `hex_out` stable. A `digit_valid` pulse during the stall is ignored. `hex_ready`=1 → IDLE next cycle.
- Reset mid-number: digits 7,8, then `rst_n`=0 for 1 cycle → all outputs at reset values. The next number 5 (last) → `hex_out`=16'h0005 with the flags clear.

Source files
------------

// File: rtl/dec_to_hex_serial.sv
// Serial BCD-to-binary converter: MSD-first digits in, binary result out on a valid/ready handshake.
// Optional build macro DEC_TO_HEX_SAT_EN saturates hex_out to all ones on overflow.
module dec_to_hex_serial #(
  parameter int N_DIGITS = 5,
  parameter int WIDTH    = 16,
  localparam int CW      = $clog2(N_DIGITS + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_digit_valid,
  input  logic [3:0]       i_digit,
  input  logic             i_digit_last,
  output logic             o_digit_ready,
  output logic [WIDTH-1:0] o_hex_out,
  output logic             o_hex_valid,
  input  logic             i_hex_ready,
  output logic             o_overflow,
  output logic             o_err_digit,
  output logic [CW-1:0]    o_digit_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             r_overflow;
  logic             w_ovf_nxt;
  logic             r_err_digit;
  logic             w_err_nxt;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] r_hex_out;
  logic [WIDTH-1:0] w_hex_nxt;
  logic             r_hex_valid;
  logic             r_digit_ready;
  logic             w_accept;
  logic             w_bad;
  logic             w_full;
  logic [3:0]       w_d;
  logic [WIDTH+3:0] w_mac;

  // acc*10 + d evaluated four bits wide of the result so any carry out is visible
  function automatic logic [WIDTH+3:0] mac10(input logic [WIDTH-1:0] acc, input logic [3:0] d);
    logic [WIDTH+3:0] ext;
    ext = {4'd0, acc};
    return (ext << 3) + (ext << 1) + {{WIDTH{1'b0}}, d};
  endfunction

  // Next-state and datapath update for the current handshake
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_ovf_nxt   = r_overflow;
    w_err_nxt   = r_err_digit;
    w_count_nxt = r_count;
    w_hex_nxt   = r_hex_out;
    w_accept    = i_digit_valid & r_digit_ready;
    w_bad       = (i_digit > 4'd9);
    w_d         = w_bad ? 4'd0 : i_digit;
    w_full      = (r_count == CW'(N_DIGITS));
    w_mac       = mac10(r_acc, w_d);

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_acc_nxt   = WIDTH'(w_d);
          w_ovf_nxt   = 1'b0;
          w_err_nxt   = w_bad;
          w_count_nxt = CW'(1);
          w_state_nxt = i_digit_last ? S_HOLD : S_ACCUM;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACCUM: begin
        if (w_accept) begin
          // Digits beyond N_DIGITS are swallowed but still flag overflow
          if (w_full) begin
            w_ovf_nxt = 1'b1;
          end else begin
            w_acc_nxt   = w_mac[WIDTH-1:0];
            w_ovf_nxt   = r_overflow | (|w_mac[WIDTH+3:WIDTH]);
            w_count_nxt = r_count + CW'(1);
          end
          w_err_nxt   = r_err_digit | w_bad;
          w_state_nxt = i_digit_last ? S_HOLD : S_ACCUM;
        end else begin
          w_state_nxt = S_ACCUM;
        end
      end
      S_HOLD: begin
        if (i_hex_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_state_nxt == S_HOLD) begin
`ifdef DEC_TO_HEX_SAT_EN
      w_hex_nxt = w_ovf_nxt ? {WIDTH{1'b1}} : w_acc_nxt;
`else
      w_hex_nxt = w_acc_nxt;
`endif
    end else begin
      w_hex_nxt = r_hex_out;
    end
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_acc         <= '0;
      r_overflow    <= 1'b0;
      r_err_digit   <= 1'b0;
      r_count       <= '0;
      r_hex_out     <= '0;
      r_hex_valid   <= 1'b0;
      r_digit_ready <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_acc         <= w_acc_nxt;
      r_overflow    <= w_ovf_nxt;
      r_err_digit   <= w_err_nxt;
      r_count       <= w_count_nxt;
      r_hex_out     <= w_hex_nxt;
      r_hex_valid   <= (w_state_nxt == S_HOLD);
      r_digit_ready <= (w_state_nxt != S_HOLD);
    end
  end

  assign o_digit_ready = r_digit_ready;
  assign o_hex_out     = r_hex_out;
  assign o_hex_valid   = r_hex_valid;
  assign o_overflow    = r_overflow;
  assign o_err_digit   = r_err_digit;
  assign o_digit_count = r_count;

endmodule

// File: tb/tb_dec_to_hex_serial.sv
// Directed table-driven bench for dec_to_hex_serial plus backpressure and mid-number reset sequences.
module tb_dec_to_hex_serial;

  logic        clk;
  logic        rst_n;
  logic        digit_valid;
  logic [3:0]  digit;
  logic        digit_last;
  logic        digit_ready;
  logic [15:0] hex_out;
  logic        hex_valid;
  logic        hex_ready;
  logic        overflow;
  logic        err_digit;
  logic [2:0]  digit_count;

  int vectors = 0;
  int miscompares = 0;

  dec_to_hex_serial #(.N_DIGITS(5), .WIDTH(16)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_digit_valid (digit_valid),
    .i_digit       (digit),
    .i_digit_last  (digit_last),
    .o_digit_ready (digit_ready),
    .o_hex_out     (hex_out),
    .o_hex_valid   (hex_valid),
    .i_hex_ready   (hex_ready),
    .o_overflow    (overflow),
    .o_err_digit   (err_digit),
    .o_digit_count (digit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] digits;
    int          n;
    logic [15:0] hex;
    logic        ovf;
    logic        err;
    logic [2:0]  cnt;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_hex(input logic [15:0] h, input logic ovf);
`ifdef DEC_TO_HEX_SAT_EN
    return ovf ? 16'hFFFF : h;
`else
    return h;
`endif
  endfunction

  task automatic send_digit(input logic [3:0] d, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    digit_valid = 1'b1;
    digit       = d;
    digit_last  = last;
    while (!digit_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      vectors++;
      miscompares++;
      $display("FAIL digit_ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1;
    digit_valid = 1'b0;
    digit_last  = 1'b0;
  endtask

  initial begin
    tbl[0] = '{24'h123400, 4, 16'h04D2, 1'b0, 1'b0, 3'd4};
    tbl[1] = '{24'h655350, 5, 16'hFFFF, 1'b0, 1'b0, 3'd5};
    tbl[2] = '{24'h655360, 5, 16'h0000, 1'b1, 1'b0, 3'd5};
    tbl[3] = '{24'h100007, 6, 16'h2710, 1'b1, 1'b0, 3'd5};
    tbl[4] = '{24'hA30000, 2, 16'h0003, 1'b0, 1'b1, 3'd2};
    tbl[5] = '{24'h700000, 1, 16'h0007, 1'b0, 1'b0, 3'd1};
    tbl[6] = '{24'h999990, 5, 16'h869F, 1'b1, 1'b0, 3'd5};
    tbl[7] = '{24'h004200, 4, 16'h002A, 1'b0, 1'b0, 3'd4};

    rst_n       = 1'b0;
    digit_valid = 1'b0;
    digit       = 4'd0;
    digit_last  = 1'b0;
    hex_ready   = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_digit_ready", {31'd0, digit_ready}, 32'd0);
    chk("rst_hex_valid",   {31'd0, hex_valid},   32'd0);
    chk("rst_hex_out",     {16'd0, hex_out},     32'd0);
    chk("rst_overflow",    {31'd0, overflow},    32'd0);
    chk("rst_err_digit",   {31'd0, err_digit},   32'd0);
    chk("rst_digit_count", {29'd0, digit_count}, 32'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < tbl[v].n; k++) begin
        send_digit(tbl[v].digits[23-4*k -: 4], (k == tbl[v].n - 1));
      end
      @(negedge clk);
      chk($sformatf("v%0d_hex_valid", v),   {31'd0, hex_valid},   32'd1);
      chk($sformatf("v%0d_digit_ready", v), {31'd0, digit_ready}, 32'd0);
      chk($sformatf("v%0d_hex_out", v),     {16'd0, hex_out},     {16'd0, exp_hex(tbl[v].hex, tbl[v].ovf)});
      chk($sformatf("v%0d_overflow", v),    {31'd0, overflow},    {31'd0, tbl[v].ovf});
      chk($sformatf("v%0d_err_digit", v),   {31'd0, err_digit},   {31'd0, tbl[v].err});
      chk($sformatf("v%0d_digit_count", v), {29'd0, digit_count}, {29'd0, tbl[v].cnt});
      @(negedge clk);
      chk($sformatf("v%0d_idle_valid", v), {31'd0, hex_valid},   32'd0);
      chk($sformatf("v%0d_idle_ready", v), {31'd0, digit_ready}, 32'd1);
      chk($sformatf("v%0d_idle_count", v), {29'd0, digit_count}, {29'd0, tbl[v].cnt});
    end

    // Backpressure: result held for 5 stall cycles, stray digit pulse ignored
    hex_ready = 1'b0;
    send_digit(4'd9, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_hex_valid", c),   {31'd0, hex_valid},   32'd1);
      chk($sformatf("bp%0d_digit_ready", c), {31'd0, digit_ready}, 32'd0);
      chk($sformatf("bp%0d_hex_out", c),     {16'd0, hex_out},     32'h0009);
      digit_valid = (c == 1);
      digit       = 4'd5;
      digit_last  = (c == 1);
    end
    digit_valid = 1'b0;
    digit_last  = 1'b0;
    hex_ready   = 1'b1;
    @(negedge clk);
    chk("bp_idle_valid", {31'd0, hex_valid},   32'd0);
    chk("bp_idle_ready", {31'd0, digit_ready}, 32'd1);
    chk("bp_idle_hex",   {16'd0, hex_out},     32'h0009);
    chk("bp_idle_count", {29'd0, digit_count}, 32'd1);

    // Reset in the middle of a number discards it
    send_digit(4'd7, 1'b0);
    send_digit(4'd8, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_digit_ready", {31'd0, digit_ready}, 32'd0);
    chk("mrst_hex_valid",   {31'd0, hex_valid},   32'd0);
    chk("mrst_hex_out",     {16'd0, hex_out},     32'd0);
    chk("mrst_overflow",    {31'd0, overflow},    32'd0);
    chk("mrst_err_digit",   {31'd0, err_digit},   32'd0);
    chk("mrst_digit_count", {29'd0, digit_count}, 32'd0);
    rst_n = 1'b1;
    send_digit(4'd5, 1'b1);
    @(negedge clk);
    chk("post_rst_valid",    {31'd0, hex_valid},   32'd1);
    chk("post_rst_hex",      {16'd0, hex_out},     32'h0005);
    chk("post_rst_overflow", {31'd0, overflow},    32'd0);
    chk("post_rst_err",      {31'd0, err_digit},   32'd0);
    chk("post_rst_count",    {29'd0, digit_count}, 32'd1);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
